// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard receiver with make/break/extended decoding into held arrow-key flags.
// Optional build macro PS2_WASD_EN adds non-extended W/A/S/D keys as a second direction source.
module ps2_arrow_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

  // Direction masks are ordered {up, down, left, right}.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    case (code)
      8'h75:   arrow_mask = 4'b1000;
      8'h72:   arrow_mask = 4'b0100;
      8'h6B:   arrow_mask = 4'b0010;
      8'h74:   arrow_mask = 4'b0001;
      default: arrow_mask = 4'b0000;
    endcase
  endfunction

`ifdef PS2_WASD_EN
  function automatic logic [3:0] wasd_mask(input logic [7:0] code);
    case (code)
      8'h1D:   wasd_mask = 4'b1000;
      8'h1B:   wasd_mask = 4'b0100;
      8'h1C:   wasd_mask = 4'b0010;
      8'h23:   wasd_mask = 4'b0001;
      default: wasd_mask = 4'b0000;
    endcase
  endfunction
`endif

  // Stage p0: two-flop synchronisers, idle-high.
  logic clk_s1_p0, clk_s2_p0, dat_s1_p0, dat_s2_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_p0 <= 1'b1;
      clk_s2_p0 <= 1'b1;
      dat_s1_p0 <= 1'b1;
      dat_s2_p0 <= 1'b1;
    end else begin
      clk_s1_p0 <= PS2Clk;
      clk_s2_p0 <= clk_s1_p0;
      dat_s1_p0 <= PS2Data;
      dat_s2_p0 <= dat_s1_p0;
    end
  end

  // Stage p1: PS2Clk glitch filter; data is captured as the filtered clock falls.
  logic           clk_f_p1;
  logic [FCW-1:0] fcnt_p1;
  logic           vld_p1;
  logic           bit_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_f_p1 <= 1'b1;
      fcnt_p1  <= '0;
      vld_p1   <= 1'b0;
      bit_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (clk_s2_p0 != clk_f_p1) begin
        if (fcnt_p1 == FCW'(FILTER_LEN - 1)) begin
          clk_f_p1 <= clk_s2_p0;
          fcnt_p1  <= '0;
          vld_p1   <= clk_f_p1;
          bit_p1   <= dat_s2_p0;
        end else begin
          fcnt_p1 <= fcnt_p1 + 1'b1;
        end
      end else begin
        fcnt_p1 <= '0;
      end
    end
  end

  // Stage p2: frame shift register, bit count and mid-frame timeout.
  logic [10:0]    shreg_p2;
  logic [3:0]     bitcnt_p2;
  logic [TCW-1:0] tocnt_p2;
  logic           vld_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_p2  <= '0;
      bitcnt_p2 <= '0;
      tocnt_p2  <= '0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      if (vld_p1) begin
        shreg_p2 <= {bit_p1, shreg_p2[10:1]};
        tocnt_p2 <= '0;
        if (bitcnt_p2 == 4'd10) begin
          bitcnt_p2 <= '0;
          vld_p2    <= 1'b1;
        end else begin
          bitcnt_p2 <= bitcnt_p2 + 1'b1;
        end
      end else if (bitcnt_p2 != 4'd0) begin
        if (tocnt_p2 == TCW'(TIMEOUT_CYC - 1))
          bitcnt_p2 <= '0;
        else
          tocnt_p2 <= tocnt_p2 + 1'b1;
      end else begin
        tocnt_p2 <= '0;
      end
    end
  end

  // Frame layout after 11 shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  logic       frame_ok;
  logic [7:0] code;
  assign code     = shreg_p2[8:1];
  assign frame_ok = vld_p2 && !shreg_p2[0] && shreg_p2[10] && (^shreg_p2[9:1]);

  state_t     state, state_nx;
  logic [3:0] arr_q, arr_nx;
`ifdef PS2_WASD_EN
  logic [3:0] wasd_q, wasd_nx;
`endif

  always_comb begin
    state_nx = state;
    arr_nx   = arr_q;
`ifdef PS2_WASD_EN
    wasd_nx  = wasd_q;
`endif
    if (frame_ok) begin
      case (state)
        ST_IDLE: begin
          if (code == 8'hE0)      state_nx = ST_EXT;
          else if (code == 8'hF0) state_nx = ST_BRK;
          else                    state_nx = ST_IDLE;
`ifdef PS2_WASD_EN
          wasd_nx = wasd_q | wasd_mask(code);
`endif
        end
        ST_EXT: begin
          if (code == 8'hF0) begin
            state_nx = ST_EXT_BRK;
          end else begin
            arr_nx   = arr_q | arrow_mask(code);
            state_nx = ST_IDLE;
          end
        end
        ST_BRK: begin
`ifdef PS2_WASD_EN
          wasd_nx = wasd_q & ~wasd_mask(code);
`endif
          state_nx = ST_IDLE;
        end
        default: begin
          arr_nx   = arr_q & ~arrow_mask(code);
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Stage p3: registered outputs; flags move on the same edge as scan_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      arr_q      <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_WASD_EN
      wasd_q     <= '0;
`endif
    end else begin
      state      <= state_nx;
      arr_q      <= arr_nx;
      scan_valid <= frame_ok;
      frame_err  <= vld_p2 && !frame_ok;
      if (frame_ok) scan_code <= code;
`ifdef PS2_WASD_EN
      wasd_q     <= wasd_nx;
`endif
    end
  end

`ifdef PS2_WASD_EN
  assign {up, down, left, right} = arr_q | wasd_q;
`else
  assign {up, down, left, right} = arr_q;
`endif

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed testbench for ps2_arrow_decoder: emulates a PS/2 keyboard and checks decoded outputs.
`timescale 1ns/1ps
module tb_ps2_arrow_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       PS2Clk = 1'b1;
  logic       PS2Data = 1'b1;
  logic       up, down, left, right;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int sv_cnt = 0;
  int err_cnt = 0;
  logic [3:0] dirs_at_sv = 4'b0000;

  ps2_arrow_decoder dut (
    .clk(clk), .reset(reset), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
    .up(up), .down(down), .left(left), .right(right),
    .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scan_valid) begin
      sv_cnt++;
      dirs_at_sv = {up, down, left, right};
    end
    if (frame_err) err_cnt++;
  end

  task automatic ps2_bit(input logic b);
    PS2Data = b;
    repeat (10) @(posedge clk);
    PS2Clk = 1'b0;
    repeat (20) @(posedge clk);
    PS2Clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({up, down, left, right} !== 4'b0000 || scan_code !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs dirs=%b code=%h want dirs=0000 code=00", {up, down, left, right}, scan_code);
    end
    checks++;
    if (scan_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses valid=%b err=%b want 0 0", scan_valid, frame_err);
    end
    reset = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_arrow_make();
    int sv0 = sv_cnt;
    int er0 = err_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (sv_cnt - sv0 !== 2 || err_cnt - er0 !== 0) begin
      errors++;
      $display("FAIL make_pulses valid=%0d err=%0d want 2 0", sv_cnt - sv0, err_cnt - er0);
    end
    checks++;
    if (scan_code !== 8'h75) begin
      errors++;
      $display("FAIL make_code got %h want 75", scan_code);
    end
    checks++;
    if ({up, down, left, right} !== 4'b1000) begin
      errors++;
      $display("FAIL make_up dirs=%b want 1000", {up, down, left, right});
    end
  endtask

  task automatic test_typematic_opposite();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    checks++;
    if ({up, down, left, right} !== 4'b1000) begin
      errors++;
      $display("FAIL typematic dirs=%b want 1000", {up, down, left, right});
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'h72, 1'b0);
    checks++;
    if ({up, down, left, right} !== 4'b1100) begin
      errors++;
      $display("FAIL opposite dirs=%b want 1100", {up, down, left, right});
    end
  endtask

  task automatic test_arrow_break();
    int sv0 = sv_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    checks++;
    if (sv_cnt - sv0 !== 3 || scan_code !== 8'h75) begin
      errors++;
      $display("FAIL break_frames valid=%0d code=%h want 3 75", sv_cnt - sv0, scan_code);
    end
    checks++;
    if (dirs_at_sv !== 4'b0100) begin
      errors++;
      $display("FAIL break_edge dirs_at_valid=%b want 0100", dirs_at_sv);
    end
    checks++;
    if ({up, down, left, right} !== 4'b0100) begin
      errors++;
      $display("FAIL break_up dirs=%b want 0100", {up, down, left, right});
    end
  endtask

  task automatic test_parity_err();
    int sv0 = sv_cnt;
    int er0 = err_cnt;
    send_byte(8'h6B, 1'b1);
    checks++;
    if (err_cnt - er0 !== 1 || sv_cnt - sv0 !== 0) begin
      errors++;
      $display("FAIL parity_pulses err=%0d valid=%0d want 1 0", err_cnt - er0, sv_cnt - sv0);
    end
    checks++;
    if (scan_code !== 8'h75 || left !== 1'b0) begin
      errors++;
      $display("FAIL parity_hold code=%h left=%b want 75 0", scan_code, left);
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    checks++;
    if ({up, down, left, right} !== 4'b0110 || dirs_at_sv !== 4'b0110) begin
      errors++;
      $display("FAIL parity_recover dirs=%b at_valid=%b want 0110", {up, down, left, right}, dirs_at_sv);
    end
  endtask

  task automatic test_break_not_held();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h74, 1'b0);
    checks++;
    if ({up, down, left, right} !== 4'b0110 || scan_code !== 8'h74) begin
      errors++;
      $display("FAIL stray_break dirs=%b code=%h want 0110 74", {up, down, left, right}, scan_code);
    end
  endtask

  task automatic test_passthrough();
    send_byte(8'hAA, 1'b0);
    checks++;
    if (scan_code !== 8'hAA || {up, down, left, right} !== 4'b0110) begin
      errors++;
      $display("FAIL passthrough code=%h dirs=%b want AA 0110", scan_code, {up, down, left, right});
    end
  endtask

  task automatic test_timeout();
    int sv0 = sv_cnt;
    int er0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    PS2Data = 1'b1;
    repeat (25000) @(posedge clk);
    #1;
    checks++;
    if (sv_cnt - sv0 !== 0 || err_cnt - er0 !== 0) begin
      errors++;
      $display("FAIL timeout_silent valid=%0d err=%0d want 0 0", sv_cnt - sv0, err_cnt - er0);
    end
    send_byte(8'h74, 1'b0);
    checks++;
    if (sv_cnt - sv0 !== 1 || err_cnt - er0 !== 0 || scan_code !== 8'h74) begin
      errors++;
      $display("FAIL timeout_realign valid=%0d err=%0d code=%h want 1 0 74", sv_cnt - sv0, err_cnt - er0, scan_code);
    end
    checks++;
    if (right !== 1'b0) begin
      errors++;
      $display("FAIL keypad_right got %b want 0", right);
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    checks++;
    if ({up, down, left, right} !== 4'b0111) begin
      errors++;
      $display("FAIL ext_right dirs=%b want 0111", {up, down, left, right});
    end
  endtask

  task automatic test_glitch();
    int sv0 = sv_cnt;
    int er0 = err_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2 PS2Clk = 1'b0;
      #1 PS2Clk = 1'b1;
      repeat (5) @(posedge clk);
      PS2Clk = 1'b0;
      repeat (3) @(posedge clk);
      PS2Clk = 1'b1;
      repeat (5) @(posedge clk);
    end
    send_byte(8'hFA, 1'b0);
    checks++;
    if (sv_cnt - sv0 !== 1 || err_cnt - er0 !== 0 || scan_code !== 8'hFA) begin
      errors++;
      $display("FAIL glitch valid=%0d err=%0d code=%h want 1 0 FA", sv_cnt - sv0, err_cnt - er0, scan_code);
    end
  endtask

  task automatic test_reset_mid_frame();
    int er0;
    checks++;
    if (down !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_down got %b want 1", down);
    end
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({up, down, left, right} !== 4'b0000 || scan_code !== 8'h00 || scan_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid dirs=%b code=%h valid=%b want 0000 00 0", {up, down, left, right}, scan_code, scan_valid);
    end
    repeat (3) @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    er0 = err_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    checks++;
    if ({up, down, left, right} !== 4'b0010 || err_cnt - er0 !== 0) begin
      errors++;
      $display("FAIL after_reset dirs=%b err=%0d want 0010 0", {up, down, left, right}, err_cnt - er0);
    end
  endtask

`ifdef PS2_WASD_EN
  task automatic test_wasd();
    send_byte(8'h1D, 1'b0);
    checks++;
    if ({up, down, left, right} !== 4'b1010) begin
      errors++;
      $display("FAIL wasd_make dirs=%b want 1010", {up, down, left, right});
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    checks++;
    if (up !== 1'b1) begin
      errors++;
      $display("FAIL wasd_overlap up=%b want 1", up);
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    checks++;
    if ({up, down, left, right} !== 4'b0010) begin
      errors++;
      $display("FAIL wasd_release dirs=%b want 0010", {up, down, left, right});
    end
  endtask
`else
  task automatic test_wasd();
    send_byte(8'h1D, 1'b0);
    checks++;
    if ({up, down, left, right} !== 4'b0010 || scan_code !== 8'h1D) begin
      errors++;
      $display("FAIL wasd_off dirs=%b code=%h want 0010 1D", {up, down, left, right}, scan_code);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_arrow_make();
    test_typematic_opposite();
    test_arrow_break();
    test_parity_err();
    test_break_not_held();
    test_passthrough();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    test_wasd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
